// File: rtl/digit_scan_mux_pkg.sv
// Shared constants and types for the seven-segment digit scan controller.
package digit_scan_mux_pkg;

    // Width of one digit code, matching the segment decoder input.
    localparam int DIG_W_C = 3;

    // Digit codes understood by the downstream decoder.
    localparam logic [DIG_W_C-1:0] CODE_0     = 3'd0;
    localparam logic [DIG_W_C-1:0] CODE_1     = 3'd1;
    localparam logic [DIG_W_C-1:0] CODE_2     = 3'd2;
    localparam logic [DIG_W_C-1:0] CODE_3     = 3'd3;
    localparam logic [DIG_W_C-1:0] CODE_4     = 3'd4;
    localparam logic [DIG_W_C-1:0] CODE_5     = 3'd5;
    localparam logic [DIG_W_C-1:0] CODE_BLANK = 3'd7;

    // Scan slot type: anodes dark, or one digit lit.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // clog2 that never collapses to a zero-width vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/digit_scan_mux_scan_timer.sv
// Loadable down-counter timing one BLANK or SHOW slot.
// tc is high while the count sits at zero, i.e. in the last cycle of a slot.
module digit_scan_mux_scan_timer
    import digit_scan_mux_pkg::*;
#(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    // Count register: clear beats load, load beats decrement, hold at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Alternates BLANK (all anodes off) and SHOW (one anode low) slots, presenting
// a per-frame snapshot of Digits so a frame never tears.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIG_W        = DIG_W_C,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Enable,
    input  logic [NUM_DIGITS*DIG_W-1:0] Digits,
    output logic [DIG_W-1:0]            Dig,
    output logic                        Ghost,
    output logic [NUM_DIGITS-1:0]       An,
    output logic                        Frame
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = clog2_min1(MAX_CYC);
    localparam int IDX_W   = clog2_min1(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                          state, state_nx;
    logic                                 run, run_nx;
    logic [IDX_W-1:0]                     idx, idx_nx;
    logic [DIG_W-1:0]                     dig_q, dig_nx;
    logic                                 ghost_q, ghost_nx;
    logic [NUM_DIGITS-1:0]                an_q, an_nx;
    logic                                 frame_q, frame_nx;
    logic [NUM_DIGITS-1:0][DIG_W-1:0]     snap, snap_nx;

    logic                                 t_clr, t_load, t_tc;
    logic [CNT_W-1:0]                     t_val, t_count;

    digit_scan_mux_scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (Clk),
        .rst      (Rst),
        .clr      (t_clr),
        .load     (t_load),
        .load_val (t_val),
        .count    (t_count),
        .tc       (t_tc)
    );

    // Ghost level for a lit slot; leading zeros are forced dark when enabled.
    logic show_ghost;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    logic                  zrun;

    // Walk down from the top digit; a digit is leading-zero while every digit
    // from the top down to it is zero. Digit 0 is always shown.
    always_comb begin
        lz   = '0;
        zrun = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zrun  = zrun & (snap[i] == CODE_0);
            lz[i] = zrun;
        end
    end

    assign show_ghost = lz[idx];
`else
    assign show_ghost = 1'b0;
`endif

    // Next-state and next-output logic for the BLANK/SHOW scan sequence.
    always_comb begin
        state_nx = state;
        run_nx   = run;
        idx_nx   = idx;
        dig_nx   = dig_q;
        ghost_nx = ghost_q;
        an_nx    = an_q;
        frame_nx = 1'b0;
        snap_nx  = snap;
        t_clr    = 1'b0;
        t_load   = 1'b0;
        t_val    = '0;

        if (!Enable) begin
            // Park dark at the start of a frame until enabled again.
            state_nx = BLANK;
            run_nx   = 1'b0;
            idx_nx   = '0;
            an_nx    = '1;
            ghost_nx = 1'b1;
            t_clr    = 1'b1;
        end else if (!run) begin
            // First enabled clock: open a full blank interval for digit 0
            // and take the frame snapshot.
            run_nx  = 1'b1;
            snap_nx = Digits;
            t_load  = 1'b1;
            t_val   = BLANK_LD;
        end else begin
            case (state)
                BLANK: begin
                    if (t_tc) begin
                        state_nx = SHOW;
                        t_load   = 1'b1;
                        t_val    = DWELL_LD;
                        dig_nx   = snap[idx];
                        an_nx    = ~(NUM_DIGITS'(1) << idx);
                        ghost_nx = show_ghost;
                    end
                end
                SHOW: begin
                    if (t_tc) begin
                        state_nx = BLANK;
                        t_load   = 1'b1;
                        t_val    = BLANK_LD;
                        an_nx    = '1;
                        ghost_nx = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_nx   = '0;
                            frame_nx = 1'b1;
                            snap_nx  = Digits;
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = BLANK;
                end
            endcase
        end
    end

    // State and registered outputs; reset leaves the display dark at digit 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= BLANK;
            run     <= 1'b0;
            idx     <= '0;
            dig_q   <= '0;
            ghost_q <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
            snap    <= '0;
        end else begin
            state   <= state_nx;
            run     <= run_nx;
            idx     <= idx_nx;
            dig_q   <= dig_nx;
            ghost_q <= ghost_nx;
            an_q    <= an_nx;
            frame_q <= frame_nx;
            snap    <= snap_nx;
        end
    end

    assign Dig   = dig_q;
    assign Ghost = ghost_q;
    assign An    = an_q;
    assign Frame = frame_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux: a startup vector table, directed
// corner sequences and randomized traffic, all against a frame-position model.
module tb_digit_scan_mux;

    localparam int N      = 4;
    localparam int DW     = 3;
    localparam int DWELL  = 4;
    localparam int BLNK   = 2;
    localparam int SLOT   = DWELL + BLNK;
    localparam int PERIOD = N * SLOT;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic            Enable = 1'b1;
    logic [N*DW-1:0] Digits = '0;
    logic [DW-1:0]   Dig;
    logic            Ghost;
    logic [N-1:0]    An;
    logic            Frame;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    digit_scan_mux #(
        .NUM_DIGITS   (N),
        .DIG_W        (DW),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLNK)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Enable (Enable),
        .Digits (Digits),
        .Dig    (Dig),
        .Ghost  (Ghost),
        .An     (An),
        .Frame  (Frame)
    );

    // Reference model: outputs follow from the position inside the frame,
    // counted in clocks since the first enabled clock.
    bit                   m_run = 1'b0;
    int                   m_t = 0;
    int                   m_p = 0;
    logic [N-1:0][DW-1:0] m_snap = '0;
    logic [N-1:0]         m_an = '1;
    logic [DW-1:0]        m_dig = '0;
    logic                 m_ghost = 1'b1;
    logic                 m_frame = 1'b0;

    function automatic bit suppressed(input logic [N-1:0][DW-1:0] s, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        int hi = 0;
        for (int i = 0; i < N; i++) if (s[i] != 0) hi = i;
        return (d > hi) && (d > 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        int slot, w;
        if (Rst) begin
            m_run = 0; m_dig = '0; m_ghost = 1; m_an = '1; m_frame = 0; m_snap = '0;
        end else if (!Enable) begin
            m_run = 0; m_an = '1; m_ghost = 1; m_frame = 0;
        end else begin
            if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t++;
            m_p = m_t % PERIOD;
            if (m_p == 0) m_snap = Digits;
            slot = m_p / SLOT;
            w    = m_p % SLOT;
            m_frame = (m_p == 0) && (m_t > 0);
            if (w < BLNK) begin
                m_an = '1; m_ghost = 1;
            end else begin
                m_an    = ~(N'(1) << slot);
                m_dig   = m_snap[slot];
                m_ghost = suppressed(m_snap, slot);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then compare.
    task automatic step();
        int zeros;
        @(posedge Clk);
        model_edge();
        #1;
        check("an", 32'(An), 32'(m_an));
        check("dig", 32'(Dig), 32'(m_dig));
        check("ghost", 32'(Ghost), 32'(m_ghost));
        check("frame", 32'(Frame), 32'(m_frame));
        zeros = 0;
        for (int i = 0; i < N; i++) if (!An[i]) zeros++;
        check("an_onehot", 32'(zeros <= 1), 32'd1);
        if (An == '1) check("ghost_when_dark", 32'(Ghost), 32'd1);
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (!(m_run && m_p == target) && n < 60) begin
            step();
            n++;
        end
        check("run_until_timeout", 32'(n < 60), 32'd1);
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] an;
        logic [DW-1:0] dig;
        logic         ghost;
        logic         frame;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [N-1:0] a, input logic [DW-1:0] d,
                       input logic g, input logic f, input int n);
        vec_t v;
        v.rst = r; v.an = a; v.dig = d; v.ghost = g; v.frame = f;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        // Startup frame for Digits = {5,3,0,1}, one entry per clock.
        add(1, 4'b1111, 3'd0, 1, 0, 1);
        add(0, 4'b1111, 3'd0, 1, 0, 2);
        add(0, 4'b1110, 3'd1, 0, 0, 4);
        add(0, 4'b1111, 3'd1, 1, 0, 2);
        add(0, 4'b1101, 3'd0, 0, 0, 4);
        add(0, 4'b1111, 3'd0, 1, 0, 2);
        add(0, 4'b1011, 3'd3, 0, 0, 4);
        add(0, 4'b1111, 3'd3, 1, 0, 2);
        add(0, 4'b0111, 3'd5, 0, 0, 4);
        add(0, 4'b1111, 3'd5, 1, 1, 1);
        add(0, 4'b1111, 3'd5, 1, 0, 1);
        add(0, 4'b1110, 3'd1, 0, 0, 1);

        Digits = {3'd5, 3'd3, 3'd0, 3'd1};
        Enable = 1'b1;
        foreach (tbl[i]) begin
            Rst = tbl[i].rst;
            step();
            check("tbl_an", 32'(An), 32'(tbl[i].an));
            check("tbl_dig", 32'(Dig), 32'(tbl[i].dig));
            check("tbl_ghost", 32'(Ghost), 32'(tbl[i].ghost));
            check("tbl_frame", 32'(Frame), 32'(tbl[i].frame));
        end

        // New Digits while digit 1 is lit appear only from the next frame.
        run_until(8);
        Digits = {3'd2, 3'd2, 3'd2, 3'd2};
        run_until(14);
        check("snap_d2_old", 32'(Dig), 32'd3);
        run_until(20);
        check("snap_d3_old", 32'(Dig), 32'd5);
        run_until(2);
        check("snap_d0_new", 32'(Dig), 32'd2);
        run_until(8);
        check("snap_d1_new", 32'(Dig), 32'd2);

        // Enable drop mid-SHOW goes dark next cycle; re-enable blanks 2 clocks.
        run_until(14);
        Enable = 1'b0;
        step();
        check("dis_an", 32'(An), 32'hF);
        check("dis_ghost", 32'(Ghost), 32'd1);
        step(); step();
        Enable = 1'b1;
        step();
        check("reen_blank1", 32'(An), 32'hF);
        step();
        check("reen_blank2", 32'(An), 32'hF);
        step();
        check("reen_lit", 32'(An), 32'hE);
        check("reen_dig", 32'(Dig), 32'd2);

        // Reset during digit 3 SHOW: reset values, no Frame.
        run_until(20);
        Rst = 1'b1;
        step();
        check("rst_an", 32'(An), 32'hF);
        check("rst_ghost", 32'(Ghost), 32'd1);
        check("rst_dig", 32'(Dig), 32'd0);
        check("rst_frame", 32'(Frame), 32'd0);

        // Leading-zero patterns.
        Digits = {3'd0, 3'd0, 3'd4, 3'd0};
        Rst = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 4; i++) step();
        Rst = 1'b1;
        step();
        Digits = '0;
        Rst = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 4; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 1200; i++) begin
            Rst    = ($urandom_range(0, 99) == 0);
            Enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) Digits = (N*DW)'($urandom);
                else Digits = (N*DW)'($urandom_range(0, 63));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
